// File: rtl/dcache_assoc_ctrl.sv
// dcache_assoc_ctrl: N-way set-associative, write-back / write-allocate data
// cache controller with all tag, state and line storage held in registers.
// A miss stalls the CPU, optionally writes back a dirty victim, refills the
// line from memory, then replays the original access as a hit.
module dcache_assoc_ctrl #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WSEL_W = OFF_W - 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int ENT    = WAYS * SETS;   // storage entry = way * SETS + set

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_REPLAY    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_W-1:0]      tag_q [ENT];
  logic [TAG_W-1:0]      tag_d [ENT];
  logic [LINE_BITS-1:0]  line_q [ENT];
  logic [LINE_BITS-1:0]  line_d [ENT];
  logic [ENT-1:0]        valid_q, valid_d, dirty_q, dirty_d;
  logic [WAY_W-1:0]      rr_q [SETS];
  logic [WAY_W-1:0]      rr_d [SETS];
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]      idx_s, vidx_s;
  logic [TAG_W-1:0]      tag_s;
  logic [WSEL_W-1:0]     wsel_s;
  logic                  req_s, hit_s, acc_s;
  logic [WAY_W-1:0]      hit_way_s, vic_s;
  int                    hent_s, vent_s;
  logic                  unused_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] v);
    return (v == WAY_W'(WAYS - 1)) ? WAY_W'(0) : v + WAY_W'(1);
  endfunction

  assign unused_s = ^{p1_addr_i[1:0], req_addr_q[OFF_W-1:0]};

  // Address decode, hit lookup and victim choice for the current request.
  always_comb begin
    req_s     = p1_MemRead_i | p1_MemWrite_i;
    idx_s     = p1_addr_i[OFF_W +: IDX_W];
    tag_s     = p1_addr_i[ADDR_W-1 -: TAG_W];
    wsel_s    = p1_addr_i[2 +: WSEL_W];
    vidx_s    = req_addr_q[OFF_W +: IDX_W];
    vent_s    = int'(victim_q) * SETS + int'(vidx_s);
    hit_s     = 1'b0;
    hit_way_s = WAY_W'(0);
    vic_s     = rr_q[idx_s];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w*SETS + int'(idx_s)] && (tag_q[w*SETS + int'(idx_s)] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s     = hit_s;
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w*SETS + int'(idx_s)]) begin
        vic_s = WAY_W'(w);
      end else begin
        vic_s = vic_s;
      end
    end
    hent_s = int'(hit_way_s) * SETS + int'(idx_s);
  end

  // Next-state, storage update and output logic of the miss-handling FSM.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    line_d       = line_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    rr_d         = rr_q;
    victim_d     = victim_q;
    req_addr_d   = req_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    acc_s        = 1'b0;
    p1_data_o    = 32'd0;
    p1_stall_o   = 1'b0;
    mem_addr_o   = {ADDR_W{1'b0}};
    mem_data_o   = {LINE_BITS{1'b0}};
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && hit_s) begin
          acc_s     = 1'b1;
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (req_s) begin
          p1_stall_o = 1'b1;
          miss_cnt_d = sat_inc(miss_cnt_q);
          victim_d   = vic_s;
          req_addr_d = p1_addr_i;
          state_d    = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        p1_stall_o = 1'b1;
        if (valid_q[vent_s] && dirty_q[vent_s]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[vent_s], vidx_s, {OFF_W{1'b0}}};
        mem_data_o   = line_q[vent_s];
        if (mem_ack_i) begin
          state_d = S_ALLOCATE;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_addr_q[ADDR_W-1 -: TAG_W], vidx_s, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          line_d[vent_s]  = mem_data_i;
          tag_d[vent_s]   = req_addr_q[ADDR_W-1 -: TAG_W];
          valid_d[vent_s] = 1'b1;
          dirty_d[vent_s] = 1'b0;
          rr_d[vidx_s]    = rr_next(rr_q[vidx_s]);
          state_d         = S_REPLAY;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_REPLAY: begin
        // Completes as a hit without counting it; the miss was already counted.
        acc_s   = req_s & hit_s;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Hit access shared by IDLE and REPLAY; a combined load+store is a store.
    if (acc_s && p1_MemWrite_i) begin
      line_d[hent_s][int'(wsel_s)*32 +: 32] = p1_data_i;
      dirty_d[hent_s]                       = 1'b1;
    end else if (acc_s) begin
      p1_data_o = line_q[hent_s][int'(wsel_s)*32 +: 32];
    end else begin
      p1_data_o = 32'd0;
    end
  end

  // Control state, valid/dirty bits, pointers and counters with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      rr_q       <= '{default: '0};
      victim_q   <= '0;
      req_addr_q <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rr_q       <= rr_d;
      victim_q   <= victim_d;
      req_addr_q <= req_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and line payload; meaningless while the matching valid bit is clear.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: doc/dcache_assoc_ctrl.md
DCACHE_ASSOC_CTRL -- requirements
Module: dcache_assoc_ctrl

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 Parameter SETS, default 16, sets per way; power of two, 2..256.
REQ-003 Parameter LINE_BITS, default 256, line width; power of two, 64..512.
REQ-004 Parameter ADDR_W, default 32, byte-address width.
REQ-005 Port clk_i, in, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_i, in, 1: reset, synchronous and active-high.
REQ-007 Port p1_addr_i, in, ADDR_W: CPU byte address.
REQ-008 Port p1_data_i, in, 32: CPU store data.
REQ-009 Port p1_MemRead_i, in, 1: CPU load request.
REQ-010 Port p1_MemWrite_i, in, 1: CPU store request.
REQ-011 Port p1_data_o, out, 32: load data.
REQ-012 Port p1_stall_o, out, 1: pipeline stall.
REQ-013 Port mem_addr_o, out, ADDR_W: line-aligned memory address.
REQ-014 Port mem_data_o, out, LINE_BITS: write-back line.
REQ-015 Port mem_enable_o, out, 1: memory request.
REQ-016 Port mem_write_o, out, 1: 1 = write, 0 = read.
REQ-017 Port mem_data_i, in, LINE_BITS: refill line.
REQ-018 Port mem_ack_i, in, 1: memory completion, one-cycle pulse.
REQ-019 Port hit_cnt_o, out, 32: saturating hit counter.
REQ-020 Port miss_cnt_o, out, 32: saturating miss counter.

Function
REQ-021 Address split: offset = log2(LINE_BITS/8) LSBs, word select = offset[hi:2], index = next log2(SETS) bits, tag = remaining bits.
REQ-022 Storage: tag, valid, dirty and line per (set, way), held internally in registers; policy is write-back, write-allocate.
REQ-023 FSM states: IDLE, CHECK, WRITEBACK, ALLOCATE, REPLAY.
REQ-024 IDLE, request present, tag hit: load -> p1_data_o = selected word combinationally, p1_stall_o = 0; store -> word written and dirty set at the edge, p1_stall_o = 0.
REQ-025 IDLE, request present, miss: p1_stall_o = 1 in the same cycle, miss_cnt_o += 1, victim chosen and latched, next state CHECK.
REQ-026 Victim selection: lowest-index invalid way; if all ways are valid, the per-set round-robin pointer; the pointer advances (mod WAYS) on each allocation into that set.
REQ-027 CHECK: victim valid and dirty -> WRITEBACK; otherwise -> ALLOCATE.
REQ-028 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 0s}, mem_data_o = victim line; on mem_ack_i -> ALLOCATE.
REQ-029 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 0s}; on mem_ack_i, mem_data_i is written into the victim way with valid = 1, dirty = 0, new tag; next state REPLAY.
REQ-030 Memory handshake: mem_addr_o, mem_data_o and mem_write_o stay stable while mem_enable_o = 1; mem_ack_i is ignored when mem_enable_o = 0.
REQ-031 REPLAY: access completes as a hit per REQ-024, p1_stall_o = 0, hit_cnt_o not incremented, next state IDLE.
REQ-032 p1_stall_o = 1 in CHECK, WRITEBACK and ALLOCATE.
REQ-033 Load and store asserted together are treated as a store.
REQ-034 hit_cnt_o increments on each IDLE hit; both counters saturate at 32'hFFFFFFFF.
REQ-035 Idle outputs: mem_enable_o = 0, mem_write_o = 0; p1_data_o = 0 when no load hit.

Reset
REQ-036 rst_i high at a clock edge: state = IDLE, all valid/dirty bits = 0, round-robin pointers = 0, counters = 0; this takes priority in any state.
REQ-037 After reset, all outputs = 0 and no memory request is issued; a reset during WRITEBACK or ALLOCATE drops mem_enable_o after that edge, and dirty data is discarded.

Verification
REQ-038 Reset, then load 0x0000_0040 with memory line = word-indexed pattern -> miss, CHECK -> ALLOCATE, mem_addr_o = 0x40, mem_write_o = 0; REPLAY returns word 0; miss_cnt_o = 1, hit_cnt_o = 0.
REQ-039 Store 0xDEADBEEF to 0x44, then load 0x44 -> both stall-free, load returns 0xDEADBEEF, hit_cnt_o = 2.
REQ-040 WAYS = 2, SETS = 16: touch 0x040, 0x240, then 0x440 with 0x040 dirty -> way 0 evicted, WRITEBACK to 0x040 carrying 0xDEADBEEF in word 1, then ALLOCATE at 0x440.
REQ-041 Delay mem_ack_i by 7 cycles -> p1_stall_o, mem_enable_o and mem_addr_o held stable for all 7 cycles; a spurious ack in IDLE causes no state change.
REQ-042 Assert rst_i in the 3rd WRITEBACK cycle -> IDLE next cycle, mem_enable_o = 0, a reload of 0x040 misses, counters = 0.
REQ-043 Preload miss_cnt_o = 0xFFFFFFFF via a forced value, then cause a miss -> count stays at 0xFFFFFFFF.
